// File: rtl/vram_pkg.sv
// Shared types and constants for the video RAM arbiter and its memory clients.
package vram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    DONE = 2'd2
  } vram_state_t;

  localparam int          AW_DEFAULT = 13;
  localparam logic [12:0] FONT_BASE  = 13'h0000;
  localparam logic [12:0] TEXT_BASE  = 13'h1000;

endpackage

// File: rtl/vram_slot_decode.sv
// Decodes the adapter character phase into "adapter owns the RAM this cycle".
module vram_slot_decode
  import vram_pkg::*;
#(
  parameter int VSLOT_FIRST = 1,
  parameter int VSLOT_LAST  = 3
) (
  input  logic [2:0] i_vphase,
  output logic       o_video_slot
);

  localparam logic [2:0] SLOT_FIRST = 3'(VSLOT_FIRST);
  localparam logic [2:0] SLOT_LAST  = 3'(VSLOT_LAST);

  assign o_video_slot = (i_vphase >= SLOT_FIRST) && (i_vphase <= SLOT_LAST);

endmodule

// File: rtl/vram_arbiter.sv
// Time-slices the 8 KB video RAM between the text adapter and a CPU req/ready port.
// Build option VRAM_FONT_WP_EN: blocks CPU writes to the font area and flags them on wp_hit.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int VSLOT_FIRST = 1,
  parameter int VSLOT_LAST  = 3,
  parameter int AW          = AW_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [2:0]    vphase,
  input  logic [AW-1:0] ga_address,
  output logic [7:0]    ga_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_address,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_ready,
  output logic [7:0]    cpu_rdata,
  output logic [AW-1:0] mem_address,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  input  logic [7:0]    mem_rdata
`ifdef VRAM_FONT_WP_EN
  ,
  output logic          wp_hit
`endif
);

  vram_state_t   r_state;
  vram_state_t   w_state_next;
  logic          w_video_slot;
  logic          w_access;
  logic          w_write_ok;
  logic [AW-1:0] r_addr_q;
  logic          r_we_q;
  logic [7:0]    r_wdata_q;
  logic          r_cpu_ready;
  logic [7:0]    r_cpu_rdata;

  vram_slot_decode #(
    .VSLOT_FIRST(VSLOT_FIRST),
    .VSLOT_LAST (VSLOT_LAST)
  ) u_slot_decode (
    .i_vphase    (vphase),
    .o_video_slot(w_video_slot)
  );

`ifdef VRAM_FONT_WP_EN
  logic w_font_write;
  logic r_wp_hit;
  assign w_font_write = r_we_q && (r_addr_q < AW'(TEXT_BASE));
  assign w_write_ok   = r_we_q && !w_font_write;
  assign wp_hit       = r_wp_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wp_hit <= 1'b0;
    end else if (w_access && w_font_write) begin
      r_wp_hit <= 1'b1;
    end
  end
`else
  assign w_write_ok = r_we_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (cpu_req) w_state_next = PEND;
      PEND:    if (!w_video_slot) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // The CPU access happens in the first PEND cycle outside the adapter's slot.
  always_comb begin
    w_access    = (r_state == PEND) && !w_video_slot;
    mem_we      = w_access && w_write_ok && !reset;
    mem_address = w_video_slot ? ga_address : r_addr_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr_q    <= '0;
      r_we_q      <= 1'b0;
      r_wdata_q   <= 8'h00;
      r_cpu_ready <= 1'b0;
      r_cpu_rdata <= 8'h00;
    end else begin
      r_cpu_ready <= w_access;
      if ((r_state == IDLE) && cpu_req) begin
        r_addr_q  <= cpu_address;
        r_we_q    <= cpu_we;
        r_wdata_q <= cpu_wdata;
      end
      if (w_access && !r_we_q) begin
        r_cpu_rdata <= mem_rdata;
      end
    end
  end

  assign mem_wdata = r_wdata_q;
  assign ga_data   = mem_rdata;
  assign cpu_ready = r_cpu_ready;
  assign cpu_rdata = r_cpu_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 8 KB RAM and a phase-stepping adapter.
module tb_vram_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  vphase;
  logic [12:0] ga_address;
  logic [7:0]  ga_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_address;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready;
  logic [7:0]  cpu_rdata;
  logic [12:0] mem_address;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
`ifdef VRAM_FONT_WP_EN
  logic        wp_hit;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clock = ~clock;

  vram_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .vphase     (vphase),
    .ga_address (ga_address),
    .ga_data    (ga_data),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_address(cpu_address),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
`ifdef VRAM_FONT_WP_EN
    ,
    .wp_hit     (wp_hit)
`endif
  );

  // RAM model: asynchronous read, synchronous write, plus a bench preload port.
  logic [7:0]  ram [0:8191];
  logic        pl_en   = 1'b0;
  logic [12:0] pl_addr = 13'h0;
  logic [7:0]  pl_data = 8'h00;

  assign mem_rdata = ram[mem_address];

  always @(posedge clock) begin
    if (mem_we) ram[mem_address] <= mem_wdata;
    else if (pl_en) ram[pl_addr] <= pl_data;
  end

  // Event log: write strobes, cycle of each cpu_ready, and the phase of the access before it.
  int         cyc_cnt = 0;
  int         we_cnt  = 0;
  logic [2:0] last_ph = 3'd0;
  int         rdy_cyc[$];
  logic [2:0] rdy_acc_ph[$];

  always @(posedge clock) begin
    cyc_cnt <= cyc_cnt + 1;
    if (mem_we) we_cnt <= we_cnt + 1;
    if (cpu_ready) begin
      rdy_cyc.push_back(cyc_cnt);
      rdy_acc_ph.push_back(last_ph);
    end
    last_ph <= vphase;
  end

  task automatic advance();
    @(posedge clock);
    #1;
    vphase = vphase + 3'd1;
  endtask

  task automatic preload(input logic [12:0] a, input logic [7:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(posedge clock);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    vphase = 3'd5;
    ga_address = 13'h0A5C;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_address = 13'h0;
    cpu_wdata = 8'h00;
    preload(13'h1002, 8'h41);
    preload(13'h0A5C, 8'hC3);
    preload(13'h1003, 8'h00);
    preload(13'h1004, 8'h00);
    preload(13'h0010, 8'h12);
    preload(13'h1000, 8'h11);
    preload(13'h1100, 8'h22);
    #1;
    vectors++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b want 0", cpu_ready); end
    vectors++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", cpu_rdata); end
    vectors++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", mem_we); end
    vectors++; if (mem_address !== 13'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", mem_address); end
`ifdef VRAM_FONT_WP_EN
    vectors++; if (wp_hit !== 1'b0) begin errors++; $display("FAIL reset_wp_hit: got %0b want 0", wp_hit); end
`endif
    @(posedge clock);
    #1;
    reset = 1'b0;
    $display("tb: reset released");
  endtask

  task automatic test_read();
    @(posedge clock);
    #1;
    vphase = 3'd4;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 13'h1002;
    #1;
    vectors++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL read_idle_ready: got %0b want 0", cpu_ready); end
    advance();
    cpu_req = 1'b0; cpu_address = 13'h1FFF;
    #1;
    vectors++; if (mem_address !== 13'h1002) begin errors++; $display("FAIL read_addr: got %h want 1002", mem_address); end
    vectors++; if (mem_we !== 1'b0) begin errors++; $display("FAIL read_we: got %0b want 0", mem_we); end
    vectors++; if (ga_data !== 8'h41) begin errors++; $display("FAIL read_ga_data: got %h want 41", ga_data); end
    advance(); #1;
    vectors++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL read_ready: got %0b want 1", cpu_ready); end
    vectors++; if (cpu_rdata !== 8'h41) begin errors++; $display("FAIL read_rdata: got %h want 41", cpu_rdata); end
    advance(); #1;
    vectors++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL read_ready_1cyc: got %0b want 0", cpu_ready); end
    vectors++; if (cpu_rdata !== 8'h41) begin errors++; $display("FAIL read_rdata_hold: got %h want 41", cpu_rdata); end
    $display("tb: read 1002 -> %h", cpu_rdata);
  endtask

  task automatic test_write();
    @(posedge clock);
    #1;
    vphase = 3'd0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_address = 13'h1003; cpu_wdata = 8'h1F;
    advance();
    cpu_req = 1'b0; cpu_address = 13'h0777; cpu_wdata = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (mem_we !== 1'b0) begin errors++; $display("FAIL write_hold_we ph%0d: got %0b want 0", vphase, mem_we); end
      vectors++; if (mem_address !== 13'h0A5C) begin errors++; $display("FAIL write_hold_addr ph%0d: got %h want 0a5c", vphase, mem_address); end
      advance();
    end
    #1;
    vectors++; if (mem_we !== 1'b1) begin errors++; $display("FAIL write_we: got %0b want 1", mem_we); end
    vectors++; if (mem_address !== 13'h1003) begin errors++; $display("FAIL write_addr: got %h want 1003", mem_address); end
    vectors++; if (mem_wdata !== 8'h1F) begin errors++; $display("FAIL write_wdata: got %h want 1f", mem_wdata); end
    advance(); #1;
    vectors++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL write_ready: got %0b want 1", cpu_ready); end
    vectors++; if (mem_we !== 1'b0) begin errors++; $display("FAIL write_we_once: got %0b want 0", mem_we); end
    advance();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 13'h1003;
    advance();
    cpu_req = 1'b0;
    advance(); #1;
    vectors++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL readback_ready: got %0b want 1", cpu_ready); end
    vectors++; if (cpu_rdata !== 8'h1F) begin errors++; $display("FAIL readback_rdata: got %h want 1f", cpu_rdata); end
    $display("tb: write 1003 <- 1f, read back %h", cpu_rdata);
  endtask

  task automatic test_video_mux();
    @(posedge clock);
    #1;
    vphase = 3'd0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 13'h1100;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (vphase >= 3'd1 && vphase <= 3'd3) begin
        vectors++; if (mem_address !== 13'h0A5C) begin errors++; $display("FAIL mux_addr ph%0d: got %h want 0a5c", vphase, mem_address); end
        vectors++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mux_we ph%0d: got %0b want 0", vphase, mem_we); end
        vectors++; if (ga_data !== 8'hC3) begin errors++; $display("FAIL mux_ga_data ph%0d: got %h want c3", vphase, ga_data); end
      end
      advance();
    end
    cpu_req = 1'b0;
    #1;
    vectors++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL mux_cpu_ready: got %0b want 1", cpu_ready); end
    vectors++; if (cpu_rdata !== 8'h22) begin errors++; $display("FAIL mux_cpu_rdata: got %h want 22", cpu_rdata); end
    advance();
    $display("tb: adapter phases 1-3 served 0a5c while cpu read 1100 -> %h", cpu_rdata);
  endtask

  task automatic test_back_to_back();
    int base;
    int n;
    @(posedge clock);
    #1;
    base = rdy_cyc.size();
    vphase = 3'd0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 13'h1000;
    repeat (10) advance();
    cpu_req = 1'b0;
    repeat (10) advance();
    #1;
    n = rdy_cyc.size() - base;
    vectors++; if (n !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", n); end
    if (n == 3) begin
      vectors++; if (rdy_cyc[base+1] - rdy_cyc[base] !== 3) begin errors++; $display("FAIL b2b_gap1: got %0d want 3", rdy_cyc[base+1] - rdy_cyc[base]); end
      vectors++; if (rdy_cyc[base+2] - rdy_cyc[base+1] !== 5) begin errors++; $display("FAIL b2b_gap2: got %0d want 5", rdy_cyc[base+2] - rdy_cyc[base+1]); end
      vectors++; if (rdy_acc_ph[base] !== 3'd4) begin errors++; $display("FAIL b2b_ph1: got %0d want 4", rdy_acc_ph[base]); end
      vectors++; if (rdy_acc_ph[base+1] !== 3'd7) begin errors++; $display("FAIL b2b_ph2: got %0d want 7", rdy_acc_ph[base+1]); end
      vectors++; if (rdy_acc_ph[base+2] !== 3'd4) begin errors++; $display("FAIL b2b_ph3: got %0d want 4", rdy_acc_ph[base+2]); end
    end
    vectors++; if (cpu_rdata !== 8'h11) begin errors++; $display("FAIL b2b_rdata: got %h want 11", cpu_rdata); end
    $display("tb: back-to-back reads of 1000, %0d completions", n);
  endtask

  task automatic test_reset_pend();
    int we0;
    int rq0;
    @(posedge clock);
    #1;
    vphase = 3'd0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_address = 13'h1004; cpu_wdata = 8'h99;
    advance();
    cpu_req = 1'b0;
    repeat (3) advance();
    reset = 1'b1;
    #1;
    vectors++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rstpend_we: got %0b want 0", mem_we); end
    we0 = we_cnt;
    rq0 = rdy_cyc.size();
    advance();
    reset = 1'b0;
    #1;
    vectors++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL rstpend_ready: got %0b want 0", cpu_ready); end
    vectors++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL rstpend_rdata: got %h want 00", cpu_rdata); end
    vectors++; if (mem_address !== 13'h0000) begin errors++; $display("FAIL rstpend_addr: got %h want 0000", mem_address); end
    repeat (4) advance();
    #1;
    vectors++; if (we_cnt !== we0) begin errors++; $display("FAIL rstpend_we_count: got %0d want %0d", we_cnt, we0); end
    vectors++; if (rdy_cyc.size() !== rq0) begin errors++; $display("FAIL rstpend_ready_count: got %0d want %0d", rdy_cyc.size(), rq0); end
    vectors++; if (ram[13'h1004] !== 8'h00) begin errors++; $display("FAIL rstpend_ram: got %h want 00", ram[13'h1004]); end
    $display("tb: write 1004 aborted by reset");
  endtask

  task automatic test_font_write();
    int we0;
    @(posedge clock);
    #1;
    vphase = 3'd4;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_address = 13'h0010; cpu_wdata = 8'hFF;
    we0 = we_cnt;
    advance();
    cpu_req = 1'b0;
    #1;
`ifdef VRAM_FONT_WP_EN
    vectors++; if (mem_we !== 1'b0) begin errors++; $display("FAIL font_we: got %0b want 0", mem_we); end
`else
    vectors++; if (mem_we !== 1'b1) begin errors++; $display("FAIL font_we: got %0b want 1", mem_we); end
`endif
    advance(); #1;
    vectors++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL font_ready: got %0b want 1", cpu_ready); end
`ifdef VRAM_FONT_WP_EN
    vectors++; if (wp_hit !== 1'b1) begin errors++; $display("FAIL font_wp_hit: got %0b want 1", wp_hit); end
    vectors++; if (we_cnt !== we0) begin errors++; $display("FAIL font_we_count: got %0d want %0d", we_cnt, we0); end
    vectors++; if (ram[13'h0010] !== 8'h12) begin errors++; $display("FAIL font_ram: got %h want 12", ram[13'h0010]); end
`else
    vectors++; if (we_cnt !== we0 + 1) begin errors++; $display("FAIL font_we_count: got %0d want %0d", we_cnt, we0 + 1); end
    vectors++; if (ram[13'h0010] !== 8'hFF) begin errors++; $display("FAIL font_ram: got %h want ff", ram[13'h0010]); end
`endif
    $display("tb: font write 0010 <- ff, ram now %h", ram[13'h0010]);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_video_mux();
    test_back_to_back();
    test_reset_pend();
    test_font_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
